// File: rtl/objdma_pkg.sv
// Shared types for the object RAM DMA scheduler: copy-engine states and default copy length.
package objdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_FLUSH,
        ST_WAITEND
    } state_t;

    localparam int WORDS_DEFAULT = 2048;

endpackage

// File: rtl/objram_cpu_hold.sv
// One-deep holding register for a CPU object RAM access that arrives while the copy engine
// owns the port, plus the registered wait indication back to the CPU.
module objram_cpu_hold #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              port_busy,
    input  logic              port_busy_nx,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              pending,
    output logic              hold_wr,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_din,
    output logic              wait_n
);

    logic capture;
    logic pending_nx;

    assign capture = port_busy && req && !pending;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pending_nx = pending;
        if (capture) begin
            pending_nx = 1'b1;
        end else if (!port_busy) begin
            pending_nx = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            wait_n  <= 1'b1;
        end else if (cen) begin
            pending <= pending_nx;
            // Released on the edge into the servicing cycle, so the CPU sees it high while served.
            wait_n  <= !(pending_nx && port_busy_nx);
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed while pending is set.
    always_ff @(posedge clk) begin
        if (cen && capture) begin
            hold_wr   <= wr;
            hold_addr <= addr;
            hold_din  <= din;
        end
    end

endmodule

// File: rtl/objram_dma_scheduler.sv
// Once-per-frame object RAM -> line-buffer copy engine, started by the falling edge of the DMA
// window, sharing the object RAM port with the CPU (CPU accesses are held off during a copy).
module objram_dma_scheduler
    import objdma_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int WORDS  = WORDS_DEFAULT
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_MRST_n,
    input  logic              i_EMU_CLK6MPCEN_n,
    input  logic              i_DMA_n,
    input  logic              i_FRAMEPARITY,
    input  logic              i_CPU_REQ,
    input  logic              i_CPU_WR,
    input  logic [ADDR_W-1:0] i_CPU_ADDR,
    input  logic [DATA_W-1:0] i_CPU_DIN,
    output logic              o_CPU_WAIT_n,
    output logic [ADDR_W-1:0] o_SRC_ADDR,
    output logic              o_SRC_WE,
    output logic [DATA_W-1:0] o_SRC_DOUT,
    input  logic [DATA_W-1:0] i_SRC_DIN,
    output logic [ADDR_W-1:0] o_DST_ADDR,
    output logic              o_DST_WE,
    output logic [DATA_W-1:0] o_DST_DOUT,
    output logic              o_DST_BANK,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_ABORT
);

    // Counter is one bit wider than the address so WORDS == 2**ADDR_W still reaches its last word.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(WORDS - 1);

    state_t            state, state_nx;
    logic [ADDR_W:0]   rd_cnt;
    logic              dma_d;
    logic              cen;
    logic              start, issue, abort_now;
    logic              port_busy, port_busy_nx;
    logic              hold_pending, hold_wr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_din;

    assign cen          = !i_EMU_CLK6MPCEN_n;
    assign start        = (state == ST_IDLE) && dma_d && !i_DMA_n;
    assign port_busy    = (state == ST_COPY) || (state == ST_FLUSH);
    assign port_busy_nx = (state_nx == ST_COPY) || (state_nx == ST_FLUSH);

    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        abort_now = 1'b0;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_COPY;
            ST_COPY: begin
                if (i_DMA_n) begin
                    abort_now = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    issue = 1'b1;
                    if (rd_cnt == LAST_ADDR) state_nx = ST_FLUSH;
                end
            end
            ST_FLUSH:   state_nx = ST_WAITEND;
            ST_WAITEND: if (i_DMA_n) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state <= ST_IDLE;
        end else if (cen) begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            rd_cnt     <= '0;
            dma_d      <= 1'b0;
            o_DST_WE   <= 1'b0;
            o_DST_ADDR <= '0;
            o_DST_BANK <= 1'b0;
            o_BUSY     <= 1'b0;
            o_DONE     <= 1'b0;
            o_ABORT    <= 1'b0;
        end else if (cen) begin
            dma_d    <= i_DMA_n;
            o_DST_WE <= issue;
            o_DONE   <= (state == ST_FLUSH);
            o_BUSY   <= port_busy_nx;
            if (issue) begin
                rd_cnt     <= rd_cnt + 1'b1;
                o_DST_ADDR <= rd_cnt[ADDR_W-1:0];
            end
            if (start) begin
                rd_cnt     <= '0;
                o_DST_BANK <= !i_FRAMEPARITY;
                o_ABORT    <= 1'b0;
            end
            if (abort_now) o_ABORT <= 1'b1;
        end
    end

    objram_cpu_hold #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cpu_hold (
        .clk          (i_EMU_MCLK),
        .rst_n        (i_MRST_n),
        .cen          (cen),
        .port_busy    (port_busy),
        .port_busy_nx (port_busy_nx),
        .req          (i_CPU_REQ),
        .wr           (i_CPU_WR),
        .addr         (i_CPU_ADDR),
        .din          (i_CPU_DIN),
        .pending      (hold_pending),
        .hold_wr      (hold_wr),
        .hold_addr    (hold_addr),
        .hold_din     (hold_din),
        .wait_n       (o_CPU_WAIT_n)
    );

    // A held access takes priority over a live CPU strobe once the CPU regains the port.
    always_comb begin
        o_SRC_ADDR = i_CPU_ADDR;
        o_SRC_WE   = 1'b0;
        o_SRC_DOUT = i_CPU_DIN;
        if (port_busy) begin
            o_SRC_ADDR = rd_cnt[ADDR_W-1:0];
        end else if (hold_pending) begin
            o_SRC_ADDR = hold_addr;
            o_SRC_WE   = hold_wr;
            o_SRC_DOUT = hold_din;
        end else begin
            o_SRC_WE   = i_CPU_REQ && i_CPU_WR;
        end
    end

    assign o_DST_DOUT = i_SRC_DIN;

endmodule

// File: tb/tb_objram_dma_scheduler.sv
// Directed bench for objram_dma_scheduler with WORDS=16: behavioural object RAM and line-buffer
// models, cen at half the master clock, hand-computed expectations per scenario.
module tb_objram_dma_scheduler;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int WORDS  = 16;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              cen_n    = 1'b1;
    logic              dma_n    = 1'b1;
    logic              parity   = 1'b0;
    logic              cpu_req  = 1'b0;
    logic              cpu_wr   = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_din  = '0;
    logic              wait_n, src_we, dst_we, dst_bank, busy, done, abort;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [DATA_W-1:0] src_dout, dst_dout;
    logic [DATA_W-1:0] src_q = '0;

    always #5 clk = ~clk;

    objram_dma_scheduler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) dut (
        .i_EMU_MCLK        (clk),
        .i_MRST_n          (rst_n),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_DMA_n           (dma_n),
        .i_FRAMEPARITY     (parity),
        .i_CPU_REQ         (cpu_req),
        .i_CPU_WR          (cpu_wr),
        .i_CPU_ADDR        (cpu_addr),
        .i_CPU_DIN         (cpu_din),
        .o_CPU_WAIT_n      (wait_n),
        .o_SRC_ADDR        (src_addr),
        .o_SRC_WE          (src_we),
        .o_SRC_DOUT        (src_dout),
        .i_SRC_DIN         (src_q),
        .o_DST_ADDR        (dst_addr),
        .o_DST_WE          (dst_we),
        .o_DST_DOUT        (dst_dout),
        .o_DST_BANK        (dst_bank),
        .o_BUSY            (busy),
        .o_DONE            (done),
        .o_ABORT           (abort)
    );

    // Object RAM reads as A000+addr until written; line buffer logs every write in order.
    bit [DATA_W-1:0] src_mem [2048];
    bit              src_set [2048];
    bit [DATA_W-1:0] lb [2][2048];
    int              wr_addr_q[$];
    int              wr_data_q[$];
    int              wr_bank_q[$];

    always @(posedge clk) begin
        if (!cen_n) begin
            if (src_we) begin
                src_mem[src_addr] <= src_dout;
                src_set[src_addr] <= 1'b1;
            end
            src_q <= src_set[src_addr] ? src_mem[src_addr] : 16'hA000 + 16'(src_addr);
            if (dst_we) begin
                lb[dst_bank][dst_addr] <= dst_dout;
                wr_addr_q.push_back(int'(dst_addr));
                wr_data_q.push_back(int'(dst_dout));
                wr_bank_q.push_back(int'(dst_bank));
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cen cycle: cen low for one master clock, high for the next; sample after it.
    task automatic cyc();
        cen_n = 1'b0;
        @(posedge clk); #1;
        cen_n = 1'b1;
        @(posedge clk); #1;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic check_full_copy(input string tag, input int base, input int bank_exp);
        check({tag, "_count"}, wr_addr_q.size() - base, WORDS);
        for (int i = 0; i < WORDS; i++) begin
            if (base + i < wr_addr_q.size()) begin
                check({tag, "_addr"}, wr_addr_q[base+i], i);
                check({tag, "_bank"}, wr_bank_q[base+i], bank_exp);
            end
        end
    endtask

    int base;

    initial begin
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_wait_n", wait_n, 1);
        check("rst_src_we", src_we, 0);
        check("rst_dst_we", dst_we, 0);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_abort",  abort,  0);
        check("rst_bank",   dst_bank, 0);
        run(2);

        // Full copy, parity 0 -> bank 1
        base   = wr_addr_q.size();
        parity = 1'b0;
        dma_n  = 1'b0;
        cyc();
        check("t1_busy_start", busy, 1);
        clear_counts();
        run(16);
        check("t1_busy_copy", busy_cnt, 16);
        check("t1_no_early_done", done_cnt, 0);
        cyc();
        check("t1_done_at_17", done, 1);
        check("t1_busy_off", busy, 0);
        cyc();
        check("t1_done_pulse", done, 0);
        check_full_copy("t1", base, 1);
        for (int i = 0; i < WORDS; i++) begin
            if (base + i < wr_data_q.size())
                check("t1_data", wr_data_q[base+i], 32'hA000 + i);
        end
        dma_n = 1'b1;
        run(2);

        // CPU write to addr 5 during the third COPY cycle, parity 1 -> bank 0
        base   = wr_addr_q.size();
        parity = 1'b1;
        dma_n  = 1'b0;
        cyc();
        run(2);
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 11'd5;
        cpu_din  = 16'h1234;
        check("t2_cpu_blocked", src_we, 0);
        cyc();
        cpu_req = 1'b0;
        cpu_wr  = 1'b0;
        cpu_din = 16'h0000;
        check("t2_wait_low", wait_n, 0);
        run(13);
        check("t2_wait_in_flush", wait_n, 0);
        cyc();
        check("t2_wait_released", wait_n, 1);
        check("t2_svc_addr", src_addr, 5);
        check("t2_svc_we",   src_we,   1);
        check("t2_svc_data", src_dout, 16'h1234);
        cyc();
        check("t2_cpu_landed", src_mem[5], 16'h1234);
        check("t2_copy_old",   lb[0][5],   16'hA005);
        check_full_copy("t2", base, 0);
        dma_n = 1'b1;
        run(2);

        // Abort after 6 reads, then a full copy on the next falling edge
        base   = wr_addr_q.size();
        parity = 1'b0;
        dma_n  = 1'b0;
        cyc();
        clear_counts();
        run(6);
        dma_n = 1'b1;
        cyc();
        check("t3_abort_set", abort, 1);
        check("t3_abort_busy", busy, 0);
        check("t3_abort_no_done", done_cnt, 0);
        check("t3_abort_count", wr_addr_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wr_addr_q.size())
                check("t3_abort_addr", wr_addr_q[base+i], i);
        end
        run(3);
        check("t3_abort_sticky", abort, 1);
        check("t3_no_late_write", wr_addr_q.size() - base, 6);
        base  = wr_addr_q.size();
        dma_n = 1'b0;
        cyc();
        check("t3_abort_cleared", abort, 0);
        clear_counts();
        run(18);
        check("t3_done_once", done_cnt, 1);
        check_full_copy("t3", base, 1);

        // DMA held low for two frames' worth: no second copy without a new edge
        base = wr_addr_q.size();
        clear_counts();
        run(40);
        check("t4_no_restart_done", done_cnt, 0);
        check("t4_no_restart_busy", busy_cnt, 0);
        check("t4_no_restart_wr", wr_addr_q.size() - base, 0);
        dma_n = 1'b1;
        cyc();
        dma_n = 1'b0;
        cyc();
        check("t4_restart_busy", busy, 1);
        clear_counts();
        run(18);
        check("t4_restart_done", done_cnt, 1);
        check_full_copy("t4", base, 1);
        dma_n = 1'b1;
        run(2);

        // Reset asserted mid-COPY
        dma_n = 1'b0;
        cyc();
        run(5);
        check("t5_pre_dst_we", dst_we, 1);
        check("t5_pre_bank", dst_bank, 1);
        base = wr_addr_q.size();
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_dst_we", dst_we,   0);
        check("t5_rst_busy",   busy,     0);
        check("t5_rst_bank",   dst_bank, 0);
        check("t5_rst_wait_n", wait_n,   1);
        check("t5_rst_done",   done,     0);
        check("t5_rst_abort",  abort,    0);
        check("t5_rst_src_we", src_we,   0);
        run(3);
        check("t5_no_write_in_rst", wr_addr_q.size() - base, 0);
        dma_n = 1'b1;
        #3 rst_n = 1'b1;
        cpu_addr = 11'd7;
        run(2);
        check("t5_idle_cpu_port", src_addr, 7);
        check("t5_idle_busy", busy, 0);

        // cen held off for 10 master clocks mid-COPY
        base   = wr_addr_q.size();
        parity = 1'b1;
        dma_n  = 1'b0;
        cyc();
        run(4);
        check("t6_pre_src_addr", src_addr, 4);
        check("t6_pre_writes", wr_addr_q.size() - base, 3);
        repeat (10) @(posedge clk);
        #1;
        check("t6_frozen_src_addr", src_addr, 4);
        check("t6_frozen_dst_addr", dst_addr, 3);
        check("t6_frozen_dst_we", dst_we, 1);
        check("t6_frozen_writes", wr_addr_q.size() - base, 3);
        clear_counts();
        run(13);
        check("t6_done_after_stall", done_cnt, 1);
        check_full_copy("t6", base, 0);
        dma_n = 1'b1;
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
